ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver and the next generation of the single-frame PS/2 scan-code receiver.
- Adds a configurable glitch filter, odd-parity checking, a frame timeout, a parametrised scan-code history register and a receive FIFO with a valid/ready pop interface.
- Sits between the PS/2 pins and the keyboard/command decode logic.
- All logic runs in the system clock domain.

---
 rtl/ps2_rx_fifo.sv | 250 +++++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with a glitch filter, odd-parity check, frame timeout,
// scan-code history register and a receive FIFO with a valid/ready pop interface.
//
// Ports:
//   clk, rst_n            system clock, synchronous active-low reset
//   ps2_clk, ps2_data     raw asynchronous PS/2 pins
//   code                  last HIST_BYTES good bytes, newest in [7:0]
//   byte_valid/byte_data  FIFO head, popped when byte_valid & byte_ready
//   byte_ready            consumer pop request
//   fifo_count            FIFO occupancy
//   overflow, parity_err, frame_err   sticky error flags, cleared by err_clr
//
// Optional build macro PS2_KEY_DECODE_EN adds key_valid/key_make/key_ext/key_code. The
// decoder then consumes the FIFO itself and byte_ready is ignored.
module ps2_rx_fifo #(
  parameter int unsigned FILTER_LEN  = 3,
  parameter int unsigned HIST_BYTES  = 2,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 5000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  output logic [8*HIST_BYTES-1:0]         code,
  output logic                            byte_valid,
  output logic [7:0]                      byte_data,
  input  logic                            byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow,
  output logic                            parity_err,
  output logic                            frame_err,
`ifdef PS2_KEY_DECODE_EN
  output logic                            key_valid,
  output logic                            key_make,
  output logic                            key_ext,
  output logic [7:0]                      key_code,
`endif
  input  logic                            err_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] ToLast = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Input conditioning
  logic [1:0]            clk_sync_q, dat_sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  filt_q, tick, dat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      hist_q     <= '1;
      filt_q     <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      hist_q     <= {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
      if (&hist_q)       filt_q <= 1'b1;
      else if (~|hist_q) filt_q <= 1'b0;
    end
  end

  // Tick fires in the cycle the filtered level is about to fall
  assign tick = filt_q & ~|hist_q;
  assign dat  = dat_sync_q[1];

  // Frame FSM
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          good_d, good_q;
  logic [7:0]    good_byte_q;
  logic          perr_set, ferr_set;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    good_d    = 1'b0;
    perr_set  = 1'b0;
    ferr_set  = 1'b0;
    to_cnt_d  = (state_q == StIdle || tick) ? '0 : to_cnt_q + 1'b1;
    if (tick) begin
      case (state_q)
        StIdle: begin
          if (!dat) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d   = {dat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_ok_d = ^{shift_q, dat};
          state_d  = StStop;
        end
        StStop: begin
          // A bad stop bit masks any parity failure
          if (!dat)          ferr_set = 1'b1;
          else if (par_ok_q) good_d   = 1'b1;
          else               perr_set = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && to_cnt_q == ToLast) begin
      ferr_set = 1'b1;
      state_d  = StIdle;
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_ok_q    <= 1'b0;
      to_cnt_q    <= '0;
      good_q      <= 1'b0;
      good_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_ok_q  <= par_ok_d;
      to_cnt_q  <= to_cnt_d;
      good_q    <= good_d;
      if (good_d) good_byte_q <= shift_q;
    end
  end

  // History register
  logic [8*HIST_BYTES-1:0] code_q, code_next;

  if (HIST_BYTES == 1) begin : g_hist1
    assign code_next = good_byte_q;
  end else begin : g_histn
    assign code_next = {code_q[8*HIST_BYTES-9:0], good_byte_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      code_q <= '0;
    else if (good_q) code_q <= code_next;
  end

  assign code = code_q;

  // Receive FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, pop, push, ovf_set, consumer_ready;

`ifdef PS2_KEY_DECODE_EN
  assign consumer_ready = 1'b1;
`else
  assign consumer_ready = byte_ready;
`endif

  assign byte_valid = (count_q != '0);
  assign byte_data  = mem[rd_ptr_q];
  assign fifo_count = count_q;
  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign pop        = byte_valid & consumer_ready;
  // A pop in the same cycle frees the slot the push needs
  assign push       = good_q & (~full | pop);
  assign ovf_set    = good_q & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= good_byte_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Sticky flags: a set in the same cycle as err_clr wins
  logic ovf_q, perr_q, ferr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_set  | (ovf_q  & ~err_clr);
      perr_q <= perr_set | (perr_q & ~err_clr);
      ferr_q <= ferr_set | (ferr_q & ~err_clr);
    end
  end

  assign overflow   = ovf_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

`ifdef PS2_KEY_DECODE_EN
  // Scan-code prefix decoder
  logic ext_q, brk_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      key_valid <= 1'b0;
      key_make  <= 1'b0;
      key_ext   <= 1'b0;
      key_code  <= '0;
    end else begin
      key_valid <= 1'b0;
      if (pop) begin
        if (byte_data == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (byte_data == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          key_valid <= 1'b1;
          key_make  <= ~brk_q;
          key_ext   <= ext_q;
          key_code  <= byte_data;
          ext_q     <= 1'b0;
          brk_q     <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo (default build, default parameters).
module tb_ps2_rx_fifo;

  localparam int H  = 16;    // PS/2 half-phase length in clk cycles
  localparam int TO = 5000;

  logic        clk = 1'b0;
  logic        rst_n, ps2_clk, ps2_data, byte_ready, err_clr;
  logic [15:0] code;
  logic        byte_valid, overflow, parity_err, frame_err;
  logic [7:0]  byte_data;
  logic [3:0]  fifo_count;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FILTER_LEN (3),
    .HIST_BYTES (2),
    .FIFO_DEPTH (8),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code      (code),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .err_clr   (err_clr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: expected FIFO contents, history and sticky flags
  logic [7:0]  q[$];
  logic [15:0] code_m;
  bit          ovf_m, perr_m, ferr_m;

  typedef struct {
    logic [7:0]  d;
    bit          bad_par;
    bit          bad_stop;
    int          exp_cnt;
    bit          exp_perr;
    bit          exp_ferr;
    logic [15:0] exp_code;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send the first n bits of a frame, LSB first; optional short low glitch on
  // ps2_clk during the high phase after bit glitch_at.
  task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      step(H);
      ps2_clk = 1'b0;
      step(H);
      ps2_clk = 1'b1;
      if (i == glitch_at) begin
        step(H / 2);
        ps2_clk = 1'b0;
        step(2);
        ps2_clk = 1'b1;
      end
    end
    step(H);
    ps2_data = 1'b1;
    step(H);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par,
                                           input bit bad_stop);
    logic par;
    par = ~^d ^ bad_par;
    return {~bad_stop, par, d, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int glitch_at);
    send_bits(mk_frame(d, bad_par, bad_stop), 11, glitch_at);
  endtask

  function automatic void model_frame(input logic [7:0] d, input bit bad_par,
                                      input bit bad_stop);
    if (bad_stop) ferr_m = 1'b1;
    else if (bad_par) perr_m = 1'b1;
    else begin
      code_m = {code_m[7:0], d};
      if (q.size() == 8) ovf_m = 1'b1;
      else q.push_back(d);
    end
  endfunction

  task automatic pop_check(input string name);
    chk({name, "_valid"}, 32'(byte_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk({name, "_data"}, 32'(byte_data), 32'(q[0]));
      void'(q.pop_front());
    end
    byte_ready = 1'b1;
    step(1);
    byte_ready = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    ovf_m  = 1'b0;
    perr_m = 1'b0;
    ferr_m = 1'b0;
  endtask

  task automatic chk_model(input string name);
    chk({name, "_count"}, 32'(fifo_count), 32'(q.size()));
    chk({name, "_code"}, 32'(code), 32'(code_m));
    chk({name, "_ovf"}, 32'(overflow), 32'(ovf_m));
    chk({name, "_perr"}, 32'(parity_err), 32'(perr_m));
    chk({name, "_ferr"}, 32'(frame_err), 32'(ferr_m));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1, 1'b0, 1'b0, 16'h001C};
    vecs[1] = '{8'hF0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 16'h1CF0};
    vecs[2] = '{8'h1C, 1'b1, 1'b0, 0, 1'b1, 1'b0, 16'h1CF0};
    vecs[3] = '{8'h5A, 1'b0, 1'b1, 0, 1'b0, 1'b1, 16'h1CF0};
    vecs[4] = '{8'h5A, 1'b1, 1'b1, 0, 1'b0, 1'b1, 16'h1CF0};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 16'hF000};
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 1, 1'b0, 1'b0, 16'h00FF};

    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; byte_ready = 1'b0; err_clr = 1'b0;
    step(5);
    code_m = '0; ovf_m = 1'b0; perr_m = 1'b0; ferr_m = 1'b0;
    chk("reset_valid", 32'(byte_valid), 0);
    chk_model("reset");
    rst_n = 1'b1;
    step(H);

    // Table-driven single frames
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].d, vecs[i].bad_par, vecs[i].bad_stop, -1);
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_perr", i), 32'(parity_err), 32'(vecs[i].exp_perr));
      chk($sformatf("vec%0d_ferr", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      chk($sformatf("vec%0d_code", i), 32'(code), 32'(vecs[i].exp_code));
      if (vecs[i].exp_cnt != 0) begin
        chk($sformatf("vec%0d_data", i), 32'(byte_data), 32'(vecs[i].d));
        byte_ready = 1'b1;
        step(1);
        byte_ready = 1'b0;
        chk($sformatf("vec%0d_popped", i), 32'(fifo_count), 0);
      end
      clear_errs();
      chk($sformatf("vec%0d_clr_perr", i), 32'(parity_err), 0);
      chk($sformatf("vec%0d_clr_ferr", i), 32'(frame_err), 0);
    end
    code_m = vecs[6].exp_code;

    // Glitches on ps2_clk while idle (with data low) and mid-frame
    ps2_data = 1'b0;
    step(H);
    ps2_clk = 1'b0; step(2); ps2_clk = 1'b1;
    step(H);
    ps2_data = 1'b1;
    step(H);
    send_frame(8'h3C, 1'b0, 1'b0, 4);
    model_frame(8'h3C, 1'b0, 1'b0);
    chk_model("glitch");
    pop_check("glitch_pop");

    // Timeout after 4 data bits, then a good frame
    send_bits(mk_frame(8'hA5, 1'b0, 1'b0), 5, -1);
    step(TO + 20);
    ferr_m = 1'b1;
    chk_model("timeout");
    send_frame(8'h29, 1'b0, 1'b0, -1);
    model_frame(8'h29, 1'b0, 1'b0);
    chk_model("after_timeout");
    pop_check("after_timeout_pop");
    clear_errs();

    // Randomized frames, errors and pops against the model
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      int kind, npop;
      d    = 8'($urandom);
      kind = $urandom_range(0, 7);
      send_frame(d, kind == 0, kind == 1, -1);
      model_frame(d, kind == 0, kind == 1);
      chk_model($sformatf("rand%0d", i));
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) pop_check($sformatf("rand%0d_pop", i));
      if ($urandom_range(0, 3) == 0) clear_errs();
    end

    // Drain, then overflow with 9 frames and no pops
    while (q.size() != 0) pop_check("drain");
    clear_errs();
    for (int i = 0; i < 9; i++) begin
      send_frame(8'h40 + 8'(i), 1'b0, 1'b0, -1);
      model_frame(8'h40 + 8'(i), 1'b0, 1'b0);
    end
    chk_model("overflow");
    chk("overflow_code_lo", 32'(code[7:0]), 32'h48);
    for (int i = 0; i < 8; i++) pop_check($sformatf("ovf_pop%0d", i));
    chk("ovf_empty", 32'(byte_valid), 0);
    clear_errs();

    // Reset mid-frame with data queued and a flag set
    send_frame(8'h11, 1'b0, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    chk("pre_reset_perr", 32'(parity_err), 1);
    send_bits(mk_frame(8'h77, 1'b0, 1'b0), 4, -1);
    rst_n = 1'b0;
    step(2);
    q.delete();
    code_m = '0; ovf_m = 1'b0; perr_m = 1'b0; ferr_m = 1'b0;
    chk("midreset_valid", 32'(byte_valid), 0);
    chk_model("midreset");
    rst_n = 1'b1;
    step(H);
    send_frame(8'h33, 1'b0, 1'b0, -1);
    model_frame(8'h33, 1'b0, 1'b0);
    chk_model("post_reset");
    pop_check("post_reset_pop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
